// File: rtl/sccb_pkg.sv
// Shared SCCB definitions: FSM state encoding, bus timing constants and default device ID.
// Used by both the SCCB master and the sccb_slave responder.
package sccb_pkg;

  localparam int unsigned XCLK_FREQ     = 50_000_000;
  localparam int unsigned SCCB_CLK_FREQ = 100_000;
  localparam logic [7:0]  SCCB_DEV_ID   = 8'h60;

  typedef enum logic [3:0] {
    SCCB_IDLE     = 4'd0,
    SCCB_ID       = 4'd1,
    SCCB_ID_DC    = 4'd2,
    SCCB_SUB      = 4'd3,
    SCCB_SUB_DC   = 4'd4,
    SCCB_WDATA    = 4'd5,
    SCCB_WDATA_DC = 4'd6,
    SCCB_RDATA    = 4'd7,
    SCCB_RD_NA    = 4'd8,
    SCCB_IGNORE   = 4'd9
  } sccb_state_e;

  // Bit 0 of the ID byte is the read/write flag, so only bits 7..1 identify the device.
  function automatic logic id_match(input logic [7:0] id, input logic [7:0] dev);
    return id[7:1] == dev[7:1];
  endfunction

endpackage

// File: rtl/sccb_sync_edge.sv
// Synchronizes SIO_C/SIO_D into XCLK and derives start/stop/rise/fall pulses
// from the last synchronizer stage against a one-cycle history flop.
module sccb_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic XCLK,
  input  logic RST,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic start_o,
  output logic stop_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [STAGES-1:0] scl_sync_q;
  logic [STAGES-1:0] sda_sync_q;
  logic              scl_hist_q;
  logic              sda_hist_q;
  logic              scl_s;
  logic              sda_s;

  // Reset to the idle-high bus level so leaving reset never fakes an event.
  always_ff @(posedge XCLK or negedge RST) begin
    if (!RST) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[STAGES-2:0], sda_i};
      scl_hist_q <= scl_sync_q[STAGES-1];
      sda_hist_q <= sda_sync_q[STAGES-1];
    end
  end

  assign scl_s   = scl_sync_q[STAGES-1];
  assign sda_s   = sda_sync_q[STAGES-1];
  assign sda_o   = sda_s;
  assign start_o = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
  assign stop_o  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;
  assign rise_o  = scl_s & ~scl_hist_q;
  assign fall_o  = ~scl_s & scl_hist_q;

endmodule

// File: rtl/sccb_slave.sv
// SCCB responder: decodes 3-phase writes and 2-phase reads onto a byte-wide register port.
// Define SCCB_SLAVE_AUTOINC_EN for multi-byte transfers with reg_addr auto-increment.
module sccb_slave
  import sccb_pkg::*;
#(
  parameter logic [7:0]  DEV_ID      = SCCB_DEV_ID,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       XCLK,
  input  logic       RST,
  input  logic       SIO_C,
  inout  wire        SIO_D,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  localparam logic [3:0] ST_IDLE     = SCCB_IDLE;
  localparam logic [3:0] ST_ID       = SCCB_ID;
  localparam logic [3:0] ST_ID_DC    = SCCB_ID_DC;
  localparam logic [3:0] ST_SUB      = SCCB_SUB;
  localparam logic [3:0] ST_SUB_DC   = SCCB_SUB_DC;
  localparam logic [3:0] ST_WDATA    = SCCB_WDATA;
  localparam logic [3:0] ST_WDATA_DC = SCCB_WDATA_DC;
  localparam logic [3:0] ST_RDATA    = SCCB_RDATA;
  localparam logic [3:0] ST_RD_NA    = SCCB_RD_NA;
  localparam logic [3:0] ST_IGNORE   = SCCB_IGNORE;

  logic       sda_s, start_s, stop_s, rise_s, fall_s;
  logic [3:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       rw_q, rw_d;
  logic       oe_q, oe_d;
  logic       do_q, do_d;
  logic       wr_q, wr_d;
  logic       rd_fire;
  logic [7:0] byte_in;

  sccb_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .XCLK    (XCLK),
    .RST     (RST),
    .scl_i   (SIO_C),
    .sda_i   (SIO_D),
    .sda_o   (sda_s),
    .start_o (start_s),
    .stop_o  (stop_s),
    .rise_o  (rise_s),
    .fall_o  (fall_s)
  );

  assign byte_in = {shift_q[6:0], sda_s};

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rw_d      = rw_q;
    oe_d      = oe_q;
    do_d      = do_q;
    wr_d      = 1'b0;
    rd_fire   = 1'b0;
    if (stop_s) begin
      state_d   = ST_IDLE;
      oe_d      = 1'b0;
      bit_cnt_d = 3'd0;
    end else if (start_s) begin
      state_d   = ST_ID;
      oe_d      = 1'b0;
      bit_cnt_d = 3'd0;
    end else begin
      case (state_q)
        ST_ID, ST_SUB, ST_WDATA: begin
          if (rise_s) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == ST_ID) begin
                rw_d    = byte_in[0];
                state_d = id_match(byte_in, DEV_ID) ? ST_ID_DC : ST_IGNORE;
              end else if (state_q == ST_SUB) begin
                addr_d  = byte_in;
                state_d = ST_SUB_DC;
              end else begin
                wdata_d = byte_in;
                wr_d    = 1'b1;
                state_d = ST_WDATA_DC;
              end
            end
          end
        end
        // bit_cnt 0: waiting for the fall that starts the ack bit; 1: waiting for its end.
        ST_ID_DC, ST_SUB_DC, ST_WDATA_DC: begin
          if (fall_s) begin
            if (bit_cnt_q == 3'd0) begin
              oe_d      = 1'b1;
              do_d      = 1'b0;
              bit_cnt_d = 3'd1;
            end else begin
              oe_d      = 1'b0;
              bit_cnt_d = 3'd0;
              if (state_q == ST_ID_DC) begin
                if (rw_q) begin
                  rd_fire = 1'b1;
                  shift_d = reg_rdata;
                  oe_d    = 1'b1;
                  do_d    = reg_rdata[7];
                  state_d = ST_RDATA;
                end else begin
                  state_d = ST_SUB;
                end
              end else if (state_q == ST_SUB_DC) begin
                state_d = ST_WDATA;
              end else begin
`ifdef SCCB_SLAVE_AUTOINC_EN
                addr_d  = addr_q + 8'd1;
                state_d = ST_WDATA;
`else
                state_d = ST_IGNORE;
`endif
              end
            end
          end
        end
        ST_RDATA: begin
          if (fall_s) begin
            if (bit_cnt_q == 3'd7) begin
              oe_d      = 1'b0;
              bit_cnt_d = 3'd0;
              state_d   = ST_RD_NA;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
              shift_d   = {shift_q[6:0], 1'b0};
              do_d      = shift_q[6];
            end
          end
        end
        ST_RD_NA: begin
`ifdef SCCB_SLAVE_AUTOINC_EN
          if (rise_s && bit_cnt_q == 3'd0) begin
            if (!sda_s) begin
              addr_d    = addr_q + 8'd1;
              bit_cnt_d = 3'd1;
            end else begin
              state_d = ST_IGNORE;
            end
          end else if (fall_s && bit_cnt_q == 3'd1) begin
            rd_fire   = 1'b1;
            shift_d   = reg_rdata;
            oe_d      = 1'b1;
            do_d      = reg_rdata[7];
            bit_cnt_d = 3'd0;
            state_d   = ST_RDATA;
          end
`else
          if (rise_s) begin
            state_d = ST_IGNORE;
          end
`endif
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge XCLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      addr_q    <= 8'h00;
      wdata_q   <= 8'h00;
      rw_q      <= 1'b0;
      oe_q      <= 1'b0;
      do_q      <= 1'b0;
      wr_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rw_q      <= rw_d;
      oe_q      <= oe_d;
      do_q      <= do_d;
      wr_q      <= wr_d;
    end
  end

  assign SIO_D     = oe_q ? do_q : 1'bz;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_wr    = wr_q;
  assign reg_rd    = rd_fire;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sccb_slave.sv
// Directed bench for sccb_slave: an open-drain SCCB master model drives the pins
// and a register-bank model answers reads; every scenario checks against hand-computed values.
module tb_sccb_slave;

  localparam int Q = 8;

  logic       XCLK = 1'b0;
  logic       RST = 1'b0;
  logic       SIO_C = 1'b1;
  wire        SIO_D;
  logic       m_low = 1'b0;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_wr, reg_rd, busy;
  logic [7:0] regbank [256];

  int n_vec = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int slave_low_cnt = 0;
  logic [7:0] wr_addr_log [16];
  logic [7:0] wr_data_log [16];

  assign SIO_D = m_low ? 1'b0 : 1'bz;
  pullup pu_sio (SIO_D);
  assign reg_rdata = regbank[reg_addr];

  always #10 XCLK = ~XCLK;

  sccb_slave dut (
    .XCLK      (XCLK),
    .RST       (RST),
    .SIO_C     (SIO_C),
    .SIO_D     (SIO_D),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  always @(negedge XCLK) begin
    if (reg_wr) begin
      wr_addr_log[wr_cnt[3:0]] <= reg_addr;
      wr_data_log[wr_cnt[3:0]] <= reg_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (reg_rd) rd_cnt <= rd_cnt + 1;
    if (SIO_D === 1'b0 && !m_low) slave_low_cnt <= slave_low_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge XCLK);
  endtask

  task automatic m_start();
    m_low = 1'b0; tick(Q);
    SIO_C = 1'b1; tick(Q);
    m_low = 1'b1; tick(Q);
    SIO_C = 1'b0; tick(Q);
  endtask

  task automatic m_stop();
    m_low = 1'b1; tick(Q);
    SIO_C = 1'b1; tick(Q);
    m_low = 1'b0; tick(2 * Q);
  endtask

  task automatic m_bit(input logic b, output logic r);
    m_low = ~b;   tick(Q);
    SIO_C = 1'b1; tick(Q);
    r = SIO_D;    tick(Q);
    SIO_C = 1'b0; tick(Q);
  endtask

  task automatic m_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) m_bit(d[i], r);
    m_bit(1'b1, ack);
  endtask

  task automatic m_read(input logic na, output logic [7:0] d, output logic na_line);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      m_bit(1'b1, r);
      d[i] = r;
    end
    m_bit(na, na_line);
  endtask

  task automatic test_reset();
    RST = 1'b0;
    tick(4);
    n_vec++; if (SIO_D !== 1'b1) begin n_err++; $display("FAIL rst_sio_d: got %b expected 1", SIO_D); end
    n_vec++; if (reg_addr !== 8'h00) begin n_err++; $display("FAIL rst_reg_addr: got %h expected 00", reg_addr); end
    n_vec++; if (reg_wdata !== 8'h00) begin n_err++; $display("FAIL rst_reg_wdata: got %h expected 00", reg_wdata); end
    n_vec++; if (reg_wr !== 1'b0) begin n_err++; $display("FAIL rst_reg_wr: got %b expected 0", reg_wr); end
    n_vec++; if (reg_rd !== 1'b0) begin n_err++; $display("FAIL rst_reg_rd: got %b expected 0", reg_rd); end
    RST = 1'b1;
    tick(4);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy); end
    $display("reset released");
  endtask

  task automatic test_write();
    logic a0, a1, a2;
    int w0;
    w0 = wr_cnt;
    m_start();
    m_byte(8'h60, a0);
    m_byte(8'h12, a1);
    m_byte(8'hA5, a2);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL wr_busy: got %b expected 1", busy); end
    m_stop();
    $display("write id=60 sub=12 data=a5 acks=%b%b%b", a0, a1, a2);
    n_vec++; if ({a0, a1, a2} !== 3'b000) begin n_err++; $display("FAIL wr_acks: got %b expected 000", {a0, a1, a2}); end
    n_vec++; if (wr_cnt - w0 !== 1) begin n_err++; $display("FAIL wr_count: got %0d expected 1", wr_cnt - w0); end
    n_vec++; if (wr_addr_log[w0[3:0]] !== 8'h12) begin n_err++; $display("FAIL wr_addr: got %h expected 12", wr_addr_log[w0[3:0]]); end
    n_vec++; if (wr_data_log[w0[3:0]] !== 8'hA5) begin n_err++; $display("FAIL wr_data: got %h expected a5", wr_data_log[w0[3:0]]); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL wr_busy_after_stop: got %b expected 0", busy); end
  endtask

  task automatic test_read2();
    logic a;
    logic na_line;
    logic [7:0] d;
    int w0, r0;
    w0 = wr_cnt;
    m_start(); m_byte(8'h60, a); m_byte(8'h0A, a); m_stop();
    n_vec++; if (reg_addr !== 8'h0A) begin n_err++; $display("FAIL rd_sub_addr: got %h expected 0a", reg_addr); end
    n_vec++; if (wr_cnt - w0 !== 0) begin n_err++; $display("FAIL rd_sub_no_wr: got %0d expected 0", wr_cnt - w0); end
    r0 = rd_cnt;
    m_start();
    m_byte(8'h61, a);
    m_read(1'b1, d, na_line);
    m_stop();
    $display("read id=61 addr=0a data=%h ack=%b na_line=%b", d, a, na_line);
    n_vec++; if (a !== 1'b0) begin n_err++; $display("FAIL rd_id_ack: got %b expected 0", a); end
    n_vec++; if (d !== 8'h3C) begin n_err++; $display("FAIL rd_data: got %h expected 3c", d); end
    n_vec++; if (na_line !== 1'b1) begin n_err++; $display("FAIL rd_na_released: got %b expected 1", na_line); end
    n_vec++; if (rd_cnt - r0 !== 1) begin n_err++; $display("FAIL rd_strobe_count: got %0d expected 1", rd_cnt - r0); end
    n_vec++; if (reg_addr !== 8'h0A) begin n_err++; $display("FAIL rd_addr_kept: got %h expected 0a", reg_addr); end
  endtask

  task automatic test_id_mismatch();
    logic a0, a1, a2;
    int w0, r0, l0;
    w0 = wr_cnt; r0 = rd_cnt; l0 = slave_low_cnt;
    m_start();
    m_byte(8'h42, a0);
    m_byte(8'h12, a1);
    m_byte(8'h55, a2);
    m_stop();
    $display("mismatch id=42 sub=12 data=55 acks=%b%b%b", a0, a1, a2);
    n_vec++; if ({a0, a1, a2} !== 3'b111) begin n_err++; $display("FAIL mm_acks: got %b expected 111", {a0, a1, a2}); end
    n_vec++; if (slave_low_cnt - l0 !== 0) begin n_err++; $display("FAIL mm_bus_driven: got %0d cycles expected 0", slave_low_cnt - l0); end
    n_vec++; if (wr_cnt - w0 + rd_cnt - r0 !== 0) begin n_err++; $display("FAIL mm_strobes: got %0d expected 0", wr_cnt - w0 + rd_cnt - r0); end
    n_vec++; if (reg_addr !== 8'h0A) begin n_err++; $display("FAIL mm_addr: got %h expected 0a", reg_addr); end
  endtask

  task automatic test_abort();
    logic a, r;
    int w0;
    w0 = wr_cnt;
    m_start(); m_byte(8'h60, a); m_byte(8'h34, a);
    m_bit(1'b1, r); m_bit(1'b0, r); m_bit(1'b1, r); m_bit(1'b0, r);
    m_stop();
    $display("abort id=60 sub=34 data=4 bits then stop");
    n_vec++; if (wr_cnt - w0 !== 0) begin n_err++; $display("FAIL ab_no_wr: got %0d expected 0", wr_cnt - w0); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ab_busy: got %b expected 0", busy); end
    n_vec++; if (reg_addr !== 8'h34) begin n_err++; $display("FAIL ab_addr: got %h expected 34", reg_addr); end
    w0 = wr_cnt;
    m_start(); m_byte(8'h60, a);
    m_bit(1'b0, r); m_bit(1'b1, r);
    m_start();
    m_byte(8'h60, a);
    n_vec++; if (a !== 1'b0) begin n_err++; $display("FAIL rs_id_ack: got %b expected 0", a); end
    m_byte(8'h56, a); m_byte(8'h77, a);
    m_stop();
    $display("repeated start mid-sub then write sub=56 data=77");
    n_vec++; if (wr_cnt - w0 !== 1) begin n_err++; $display("FAIL rs_wr_count: got %0d expected 1", wr_cnt - w0); end
    n_vec++; if (wr_addr_log[w0[3:0]] !== 8'h56) begin n_err++; $display("FAIL rs_wr_addr: got %h expected 56", wr_addr_log[w0[3:0]]); end
    n_vec++; if (wr_data_log[w0[3:0]] !== 8'h77) begin n_err++; $display("FAIL rs_wr_data: got %h expected 77", wr_data_log[w0[3:0]]); end
  endtask

  task automatic test_autoinc();
    logic a0, a1, a2, a3;
    int w0;
    w0 = wr_cnt;
    m_start();
    m_byte(8'h60, a0); m_byte(8'hFF, a1); m_byte(8'h11, a2); m_byte(8'h22, a3);
    m_stop();
    $display("burst id=60 sub=ff data=11,22 acks=%b%b%b%b", a0, a1, a2, a3);
    n_vec++; if ({a0, a1, a2} !== 3'b000) begin n_err++; $display("FAIL ai_acks: got %b expected 000", {a0, a1, a2}); end
    n_vec++; if (wr_addr_log[w0[3:0]] !== 8'hFF) begin n_err++; $display("FAIL ai_first_addr: got %h expected ff", wr_addr_log[w0[3:0]]); end
    n_vec++; if (wr_data_log[w0[3:0]] !== 8'h11) begin n_err++; $display("FAIL ai_first_data: got %h expected 11", wr_data_log[w0[3:0]]); end
`ifdef SCCB_SLAVE_AUTOINC_EN
    n_vec++; if (a3 !== 1'b0) begin n_err++; $display("FAIL ai_second_ack: got %b expected 0", a3); end
    n_vec++; if (wr_cnt - w0 !== 2) begin n_err++; $display("FAIL ai_wr_count: got %0d expected 2", wr_cnt - w0); end
    n_vec++; if (wr_addr_log[w0[3:0] + 4'd1] !== 8'h00) begin n_err++; $display("FAIL ai_second_addr: got %h expected 00", wr_addr_log[w0[3:0] + 4'd1]); end
    n_vec++; if (wr_data_log[w0[3:0] + 4'd1] !== 8'h22) begin n_err++; $display("FAIL ai_second_data: got %h expected 22", wr_data_log[w0[3:0] + 4'd1]); end
    n_vec++; if (reg_addr !== 8'h01) begin n_err++; $display("FAIL ai_final_addr: got %h expected 01", reg_addr); end
`else
    n_vec++; if (a3 !== 1'b1) begin n_err++; $display("FAIL ai_second_ack: got %b expected 1", a3); end
    n_vec++; if (wr_cnt - w0 !== 1) begin n_err++; $display("FAIL ai_wr_count: got %0d expected 1", wr_cnt - w0); end
    n_vec++; if (reg_addr !== 8'hFF) begin n_err++; $display("FAIL ai_final_addr: got %h expected ff", reg_addr); end
`endif
  endtask

  task automatic test_reset_mid_read();
    logic a, r;
    logic [3:0] hi;
    m_start(); m_byte(8'h60, a); m_byte(8'h0B, a); m_stop();
    m_start();
    m_byte(8'h61, a);
    for (int i = 3; i >= 0; i--) begin
      m_bit(1'b1, r);
      hi[i] = r;
    end
    n_vec++; if (hi !== 4'b1100) begin n_err++; $display("FAIL mr_upper_bits: got %b expected 1100", hi); end
    n_vec++; if (SIO_D !== 1'b0) begin n_err++; $display("FAIL mr_bit3_driven: got %b expected 0", SIO_D); end
    RST = 1'b0;
    #1;
    $display("reset asserted during read bit 3");
    n_vec++; if (SIO_D !== 1'b1) begin n_err++; $display("FAIL mr_released: got %b expected 1", SIO_D); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mr_busy: got %b expected 0", busy); end
    n_vec++; if (reg_addr !== 8'h00) begin n_err++; $display("FAIL mr_addr: got %h expected 00", reg_addr); end
    n_vec++; if (reg_wdata !== 8'h00) begin n_err++; $display("FAIL mr_wdata: got %h expected 00", reg_wdata); end
    n_vec++; if ({reg_wr, reg_rd} !== 2'b00) begin n_err++; $display("FAIL mr_strobes: got %b expected 00", {reg_wr, reg_rd}); end
    tick(4);
    RST = 1'b1;
    tick(Q);
    SIO_C = 1'b1;
    tick(2 * Q);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mr_busy_after: got %b expected 0", busy); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) regbank[i] = 8'(i) ^ 8'h5A;
    regbank[8'h0A] = 8'h3C;
    regbank[8'h0B] = 8'hC3;
    test_reset();
    test_write();
    test_read2();
    test_id_mismatch();
    test_abort();
    test_autoinc();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
